// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: pulls SYNC/LEN/payload/CHK frames from a UART rx FIFO,
// verifies the XOR checksum and replays the buffered payload on a valid/ready stream.
module uart_frame_decoder #(
    parameter int          MAX_LEN        = 16,
    parameter logic [7:0]  SYNC           = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data_i,
    input  logic       fifo_empty_i,
    output logic       fifo_rd_en_o,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic       m_last_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o
);
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_EMIT} state_t;

    state_t        state;
    logic [7:0]    buffer [MAX_LEN];
    logic [IW-1:0] len;
    logic [IW-1:0] idx;
    logic [IW-1:0] nidx;
    logic [7:0]    csum;
    logic [TW-1:0] cnt;

    // Reset gates the pop so a held-in-reset block never drains the FIFO.
    assign fifo_rd_en_o = rst && !fifo_empty_i && (state != S_EMIT);
    assign busy_o       = state != S_IDLE;
    assign nidx         = idx + IW'(1);

    always_ff @(posedge clk)
        if (state == S_PAYLOAD && fifo_rd_en_o)
            buffer[AW'(idx)] <= fifo_data_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            len         <= '0;
            idx         <= '0;
            csum        <= '0;
            cnt         <= '0;
            m_data_o    <= '0;
            m_valid_o   <= 1'b0;
            m_last_o    <= 1'b0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            err_code_o  <= '0;
        end else begin
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (fifo_rd_en_o && fifo_data_i == SYNC)
                        state <= S_LEN;
                end
                S_LEN, S_PAYLOAD, S_CHK: begin
                    if (!fifo_rd_en_o) begin
                        if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            cnt         <= '0;
                            state       <= S_IDLE;
                            frame_err_o <= 1'b1;
                            err_code_o  <= 2'd2;
                        end else begin
                            cnt <= cnt + TW'(1);
                        end
                    end else begin
                        cnt <= '0;
                        if (state == S_LEN) begin
                            if (fifo_data_i == 8'd0 || fifo_data_i > 8'(MAX_LEN)) begin
                                state       <= S_IDLE;
                                frame_err_o <= 1'b1;
                                err_code_o  <= 2'd1;
                            end else begin
                                len   <= IW'(fifo_data_i);
                                csum  <= fifo_data_i;
                                idx   <= '0;
                                state <= S_PAYLOAD;
                            end
                        end else if (state == S_PAYLOAD) begin
                            csum <= csum ^ fifo_data_i;
                            idx  <= nidx;
                            if (idx == len - IW'(1))
                                state <= S_CHK;
                        end else if (fifo_data_i == csum) begin
                            frame_ok_o <= 1'b1;
                            state      <= S_EMIT;
                            idx        <= '0;
                            m_valid_o  <= 1'b1;
                            m_data_o   <= buffer[0];
                            m_last_o   <= len == IW'(1);
                        end else begin
                            state       <= S_IDLE;
                            frame_err_o <= 1'b1;
                            err_code_o  <= 2'd3;
                        end
                    end
                end
                S_EMIT: begin
                    cnt <= '0;
                    if (m_ready_i) begin
                        if (m_last_o) begin
                            m_valid_o <= 1'b0;
                            m_last_o  <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            idx      <= nidx;
                            m_data_o <= buffer[AW'(nidx)];
                            m_last_o <= nidx == len - IW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: table-driven frame vectors plus hand sequences for
// timeout, timeout race, random backpressure and mid-frame reset.
module tb_uart_frame_decoder;
    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] fifo_data_i = 8'h00;
    logic       fifo_empty_i = 1'b1;
    logic       fifo_rd_en_o;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i = 1'b1;
    logic       m_last_o;
    logic       frame_ok_o;
    logic       frame_err_o;
    logic [1:0] err_code_o;
    logic       busy_o;

    uart_frame_decoder #(.MAX_LEN(16), .SYNC(8'hA5), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i),
        .fifo_rd_en_o(fifo_rd_en_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_last_o(m_last_o), .frame_ok_o(frame_ok_o),
        .frame_err_o(frame_err_o), .err_code_o(err_code_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           n;
        logic [159:0] b;
        int           ok;
        int           err;
        int           plen;
    } vec_t;

    vec_t       vt [5];
    int         codes [5];
    int         n_cmp = 0, n_bad = 0;
    int         cyc = 0, ok_cnt, err_cnt, ok_cyc, err_cyc, last_pop = 0;
    bit         rnd_ready = 1'b0;
    logic [7:0] q [$];
    logic [7:0] rx [$];
    logic       rxl [$];
    int         rxc [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input vec_t v, input int i);
        return v.b[(v.n - 1 - i) * 8 +: 8];
    endfunction

    task automatic drive_fifo();
        fifo_empty_i = q.size() == 0;
        fifo_data_i  = q.size() != 0 ? q[0] : 8'h00;
    endtask

    task automatic clear_mon();
        ok_cnt = 0; err_cnt = 0; ok_cyc = -1; err_cyc = -1;
        rx.delete(); rxl.delete(); rxc.delete();
    endtask

    // One clock: pre-edge handshake values are captured, post-edge outputs observed.
    task automatic step();
        logic p_rd, p_xfer, p_stall, p_l;
        logic [7:0] p_d;
        p_rd = fifo_rd_en_o;
        p_xfer = m_valid_o && m_ready_i;
        p_stall = m_valid_o && !m_ready_i;
        p_d = m_data_o;
        p_l = m_last_o;
        if (m_valid_o) chk("rd_in_emit", int'(fifo_rd_en_o), 0);
        @(posedge clk);
        #1;
        cyc++;
        if (p_rd) begin
            void'(q.pop_front());
            last_pop = cyc;
        end
        if (p_xfer) begin
            rx.push_back(p_d); rxl.push_back(p_l); rxc.push_back(cyc);
        end
        if (p_stall) begin
            chk("stall_valid", int'(m_valid_o), 1);
            chk("stall_data", int'(m_data_o), int'(p_d));
            chk("stall_last", int'(m_last_o), int'(p_l));
        end
        if (frame_ok_o) begin ok_cnt++; ok_cyc = cyc; end
        if (frame_err_o) begin
            err_cnt++; err_cyc = cyc;
            chk("busy_after_err", int'(busy_o), 0);
        end
        if (rnd_ready) m_ready_i = 1'($urandom_range(0, 1));
        drive_fifo();
        #1;
    endtask

    task automatic push_bytes(input vec_t v);
        for (int i = 0; i < v.n; i++) q.push_back(byte_at(v, i));
        drive_fifo();
        #1;
    endtask

    task automatic run_until_idle(input int maxc);
        int k = 0;
        while ((q.size() != 0 || busy_o) && k < maxc) begin step(); k++; end
        chk("idle_bound", int'(k < maxc), 1);
    endtask

    task automatic wait_drained(input int maxc);
        int k = 0;
        while (q.size() != 0 && k < maxc) begin step(); k++; end
        chk("drain_bound", int'(k < maxc), 1);
    endtask

    task automatic apply(input vec_t v, input int code);
        clear_mon();
        push_bytes(v);
        run_until_idle(200);
        chk({v.name, "_ok"}, ok_cnt, v.ok);
        chk({v.name, "_err"}, err_cnt, v.err);
        chk({v.name, "_code"}, int'(err_code_o), code);
        chk({v.name, "_busy"}, int'(busy_o), 0);
        chk({v.name, "_len"}, rx.size(), v.plen);
        for (int i = 0; i < v.plen && i < rx.size(); i++) begin
            chk({v.name, "_data"}, int'(rx[i]), int'(byte_at(v, 2 + i)));
            chk({v.name, "_last"}, int'(rxl[i]), int'(i == v.plen - 1));
            if (i > 0) chk({v.name, "_gap"}, rxc[i] - rxc[i-1], 1);
        end
        if (v.ok > 0) begin
            chk({v.name, "_okcyc"}, ok_cyc, last_pop);
            if (rx.size() > 0) chk({v.name, "_first"}, rxc[0], last_pop + 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_rx [6];
        vec_t f;
        int lp;
        vt[0] = '{"good3", 6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}), 1, 0, 3};
        vt[1] = '{"badchk", 6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04}), 0, 1, 0};
        vt[2] = '{"badlen", 6, 160'({8'h00, 8'h7F, 8'hA5, 8'h00, 8'hA5, 8'h11}), 0, 2, 0};
        vt[3] = '{"syncdata", 4, 160'({8'hA5, 8'h01, 8'hA5, 8'hA4}), 1, 0, 1};
        vt[4] = '{"maxlen", 19, 160'({8'hA5, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
                  8'h0E, 8'h0F, 8'h10}), 1, 0, 16};
        codes = '{0, 3, 1, 1, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(m_valid_o), 0);
        chk("rst_last", int'(m_last_o), 0);
        chk("rst_data", int'(m_data_o), 0);
        chk("rst_ok", int'(frame_ok_o), 0);
        chk("rst_err", int'(frame_err_o), 0);
        chk("rst_code", int'(err_code_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_rd", int'(fifo_rd_en_o), 0);
        rst = 1'b1;
        #1;

        for (int i = 0; i < 5; i++) apply(vt[i], codes[i]);

        // Inter-byte timeout, then recovery
        clear_mon();
        f = '{"to", 3, 160'({8'hA5, 8'h02, 8'h11}), 0, 0, 0};
        push_bytes(f);
        wait_drained(50);
        lp = last_pop;
        for (int k = 0; k < 3 * T && err_cnt == 0; k++) step();
        chk("to_err", err_cnt, 1);
        chk("to_delay", err_cyc - lp, T);
        chk("to_code", int'(err_code_o), 2);
        chk("to_ok", ok_cnt, 0);
        apply(vt[0], 2);

        // Byte arriving on the expiry cycle must win
        clear_mon();
        f = '{"race", 2, 160'({8'hA5, 8'h02}), 0, 0, 0};
        push_bytes(f);
        wait_drained(50);
        lp = last_pop;
        while (cyc < lp + T - 1) step();
        f = '{"race2", 3, 160'({8'h11, 8'h22, 8'h31}), 0, 0, 0};
        push_bytes(f);
        run_until_idle(100);
        chk("race_err", err_cnt, 0);
        chk("race_ok", ok_cnt, 1);
        chk("race_len", rx.size(), 2);
        if (rx.size() == 2) begin
            chk("race_d0", int'(rx[0]), 8'h11);
            chk("race_d1", int'(rx[1]), 8'h22);
        end

        // Random backpressure with the next frame already queued
        clear_mon();
        rnd_ready = 1'b1;
        f = '{"bp", 12, 160'({8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h04,
              8'hA5, 8'h01, 8'hA5, 8'hA4}), 0, 0, 0};
        push_bytes(f);
        run_until_idle(400);
        rnd_ready = 1'b0;
        m_ready_i = 1'b1;
        exp_rx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hA5};
        chk("bp_ok", ok_cnt, 2);
        chk("bp_len", rx.size(), 6);
        for (int i = 0; i < 6 && i < rx.size(); i++) begin
            chk("bp_data", int'(rx[i]), int'(exp_rx[i]));
            chk("bp_last", int'(rxl[i]), int'(i >= 4));
        end

        // Asynchronous reset in the middle of a payload
        clear_mon();
        f = '{"rs", 4, 160'({8'hA5, 8'h05, 8'h01, 8'h02}), 0, 0, 0};
        push_bytes(f);
        wait_drained(50);
        q.push_back(8'h03);
        drive_fifo();
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_rd", int'(fifo_rd_en_o), 0);
        chk("mrst_valid", int'(m_valid_o), 0);
        chk("mrst_last", int'(m_last_o), 0);
        chk("mrst_data", int'(m_data_o), 0);
        chk("mrst_ok", int'(frame_ok_o), 0);
        chk("mrst_err", int'(frame_err_o), 0);
        chk("mrst_code", int'(err_code_o), 0);
        chk("mrst_busy", int'(busy_o), 0);
        step();
        step();
        chk("mrst_nopop", q.size(), 1);
        rst = 1'b1;
        q.delete();
        drive_fifo();
        #1;
        chk("mrst_pulses", ok_cnt + err_cnt, 0);
        apply(vt[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16, giving the maximum payload bytes per frame (range 1..255).
REQ-002 The block SHALL have parameter SYNC, default 8'hA5, giving the frame start byte.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100_000, giving the inter-byte timeout in clk cycles (minimum 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port fifo_data_i, input, 8 bits: head byte of the UART rx FIFO, valid while fifo_empty_i is low.
REQ-007 The block SHALL have port fifo_empty_i, input, 1 bit: the rx FIFO is empty.
REQ-008 The block SHALL have port fifo_rd_en_o, output, 1 bit: pops the head byte; that byte is consumed in the same cycle.
REQ-009 The block SHALL have port m_data_o, output, 8 bits: payload byte.
REQ-010 The block SHALL have port m_valid_o, output, 1 bit: m_data_o and m_last_o are valid.
REQ-011 The block SHALL have port m_ready_i, input, 1 bit: the sink accepts the byte; a transfer occurs when m_valid_o and m_ready_i are both high.
REQ-012 The block SHALL have port m_last_o, output, 1 bit: marks the final payload byte of the frame.
REQ-013 The block SHALL have port frame_ok_o, output, 1 bit: one-cycle pulse when a frame passes its checksum.
REQ-014 The block SHALL have port frame_err_o, output, 1 bit: one-cycle pulse when a frame is dropped.
REQ-015 The block SHALL have port err_code_o, output, 2 bits: cause of the last drop (1 = bad length, 2 = timeout, 3 = checksum), held until the next drop.
REQ-016 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The frame format SHALL be: SYNC, LEN, LEN payload bytes, CHK, where CHK equals LEN XOR each payload byte.
REQ-018 The block SHALL use states IDLE, LEN, PAYLOAD, CHK and EMIT.
REQ-019 fifo_rd_en_o SHALL be combinational and equal to (not fifo_empty_i) and (state is not EMIT); the block SHALL never pop an empty FIFO.
REQ-020 In IDLE, the block SHALL enter LEN on a consumed byte equal to SYNC, and SHALL discard any other byte silently.
REQ-021 In LEN, a consumed byte of 0 or greater than MAX_LEN SHALL pulse frame_err_o, set err_code_o to 1 and return to IDLE.
REQ-022 In LEN, any other consumed byte SHALL be stored as the length, seed the running XOR and move to PAYLOAD.
REQ-023 In PAYLOAD, each consumed byte SHALL be written to buffer[index] and XORed into the running checksum; the block SHALL enter CHK after the LEN-th byte.
REQ-024 In CHK, a consumed byte that matches the running XOR SHALL pulse frame_ok_o in that cycle and move to EMIT.
REQ-025 In CHK, a consumed byte that does not match SHALL pulse frame_err_o, set err_code_o to 3 and return to IDLE, emitting no payload.
REQ-026 A byte equal to SYNC in LEN, PAYLOAD or CHK SHALL be treated as data, with no resynchronisation.
REQ-027 The timeout counter SHALL increment each cycle in LEN, PAYLOAD and CHK in which no byte is consumed, and SHALL clear on consumption and in IDLE and EMIT.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL pulse frame_err_o, set err_code_o to 2 and return to IDLE.
REQ-029 If a byte is consumed in the same cycle the counter would expire, the byte SHALL win and no timeout SHALL occur.
REQ-030 On the cycle after the checksum byte is consumed, m_valid_o SHALL be high with m_data_o equal to buffer[0].
REQ-031 In EMIT, each transfer SHALL advance the output index; m_last_o SHALL be high only at index LEN-1.
REQ-032 While m_valid_o is high and m_ready_i is low, m_data_o and m_last_o SHALL remain stable.
REQ-033 After the transfer with m_last_o high, the block SHALL deassert m_valid_o in the next cycle and return to IDLE.
REQ-034 In EMIT, the block SHALL not read the FIFO, so that backpressure propagates to the rx FIFO.
REQ-035 The buffer SHALL be MAX_LEN x 8 bits, and indices SHALL be clog2(MAX_LEN+1) bits wide.
REQ-036 The timeout counter SHALL be clog2(TIMEOUT_CYCLES+1) bits wide and SHALL not wrap.

Reset
REQ-037 While rst is low, the block SHALL force state to IDLE, clear all counters, indices and the checksum, and drive fifo_rd_en_o 0, m_valid_o 0, m_last_o 0, m_data_o 0, frame_ok_o 0, frame_err_o 0, err_code_o 0 and busy_o 0.
REQ-038 Reset asserted mid-frame or mid-EMIT SHALL discard the partial frame, with no frame_ok_o or frame_err_o pulse.
REQ-039 The buffer contents SHALL not require reset.

Verification
REQ-040 The bench SHALL cover: FIFO bytes A5 03 11 22 33 03 with m_ready_i high -> frame_ok_o pulse, then 11, 22, 33 on consecutive cycles, m_last_o on 33.
REQ-041 The bench SHALL cover: the same frame with CHK 04 -> frame_err_o pulse, err_code_o=3, m_valid_o never high.
REQ-042 The bench SHALL cover: bytes 00 7F A5 00 then A5 11 (with MAX_LEN=16) -> 00 and 7F dropped, err_code_o=1 twice, busy_o low after each.
REQ-043 The bench SHALL cover: A5 02 11 then FIFO empty for TIMEOUT_CYCLES cycles -> frame_err_o, err_code_o=2; a following valid frame decodes correctly.
REQ-044 The bench SHALL cover: m_ready_i toggled randomly during EMIT -> each byte delivered exactly once, in order, stable while stalled, and fifo_rd_en_o low throughout EMIT.
REQ-045 The bench SHALL cover: rst pulsed low mid-PAYLOAD -> all outputs 0 immediately, and the next complete frame decodes correctly.
